// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// ALU operation classes, opcode/funct values and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        JALEX   = 4'd12,
        JREX    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's operation class plus funct into an ALU
// control code, flagging funct values the datapath does not implement.
module aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        bad_funct
);

    always_comb begin
        alucontrol = ALU_ADD;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   bad_funct  = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath; outputs decode from the
// current state (plus the opcode latched in DECODE) and are quiet during reset.
//
// state   | meaning
// FETCH   | read instruction, PC <= PC+4
// DECODE  | decode op, branch target into aluout
// MEMADR  | compute load/store address
// MEMRD   | read data memory
// MEMWB   | write loaded data to rt
// MEMWR   | write data memory
// RTYPEEX | R-type ALU operation
// RTYPEWB | write ALU result to rd
// BEQEX   | compare, conditional branch
// IMMEX   | addi/slti ALU operation
// IMMWB   | write ALU result to rt
// JEX     | jump
// JALEX   | jump and write PC+4 to $31
// JREX    | jump to register
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic        pcwrite,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        alusrca,
    output logic        branch,
    output logic        iord,
    output logic [1:0]  memtoreg,
    output logic [1:0]  regdst,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t      state_q, state_n;
    logic [5:0]  op_q;
    aluop_t      aluop;
    logic [2:0]  alu_dec;
    logic        bad_funct;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_dec),
        .bad_funct  (bad_funct)
    );

    // op_q lets MEMADR and IMMEX pick their variant without re-reading the IR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == DECODE)
                op_q <= op;
        end
    end

    always_comb begin
        aluop = ALUOP_ADD;
        case (state_q)
            RTYPEEX: aluop = ALUOP_FUNCT;
            BEQEX:   aluop = ALUOP_SUB;
            IMMEX:   aluop = (op_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            default: aluop = ALUOP_ADD;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 2'd0;
        regdst     = 2'd0;
        alusrcb    = 2'd0;
        pcsrc      = 2'd0;
        illegal    = 1'b0;
        alucontrol = alu_dec;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'd1;
                pcwrite = 1'b1;
                state_n = DECODE;
            end
            DECODE: begin
                alusrcb = 2'd3;
                case (op)
                    OP_LW, OP_SW:    state_n = MEMADR;
                    OP_RTYPE:        state_n = (funct == FUNCT_JR) ? JREX : RTYPEEX;
                    OP_BEQ:          state_n = BEQEX;
                    OP_ADDI, OP_SLTI: state_n = IMMEX;
                    OP_J:            state_n = JEX;
                    OP_JAL:          state_n = JALEX;
                    default: begin
                        state_n = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                state_n = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                memtoreg = 2'd1;
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_n  = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                if (bad_funct) begin
                    illegal = 1'b1;
                    state_n = FETCH;
                end else begin
                    state_n = RTYPEWB;
                end
            end
            RTYPEWB: begin
                regdst   = 2'd1;
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                pcsrc   = 2'd1;
                branch  = 1'b1;
                state_n = FETCH;
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                state_n = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'd2;
                pcwrite = 1'b1;
                state_n = FETCH;
            end
            JALEX: begin
                pcsrc    = 2'd2;
                pcwrite  = 1'b1;
                regdst   = 2'd2;
                memtoreg = 2'd2;
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            JREX: begin
                pcsrc   = 2'd3;
                pcwrite = 1'b1;
                state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
        // Reset already forces FETCH; keep its write strobes from leaking out.
        if (reset) begin
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            branch   = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule
